// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RV32 opcode fields (instr[6:2]), hazard FSM encoding
// and source-register usage decode.
package pipe_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned REG_W = 5;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;

  typedef enum logic [0:0] {
    HZ_IDLE     = 1'b0,
    HZ_MDU_BUSY = 1'b1
  } hz_state_e;

  // Per-cycle pipeline control produced by the hazard controller
  typedef struct packed {
    logic stall;
    logic flush;
    logic mdu_last;
  } hz_ctrl_t;

  function automatic logic uses_rs1(input logic [OPC_W-1:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_pkg::*;

  logic [OPC_W-1:0] opcode_rg2;
  logic [OPC_W-1:0] opcode_rg3;
  logic             mext_rg2;
  logic [REG_W-1:0] rs1_rg2;
  logic [REG_W-1:0] rs2_rg2;
  logic [REG_W-1:0] rd_rg3;
  logic             br_taken_rg3;

  logic             stall_pc;
  logic             stall_rg1;
  logic             stall_rg2;
  logic             bubble_rg3;
  logic             flush_rg1;
  logic             flush_rg2;
  logic             haz;
  logic             mdu_last;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output opcode_rg2, opcode_rg3, mext_rg2, rs1_rg2, rs2_rg2, rd_rg3, br_taken_rg3,
    input  stall_pc, stall_rg1, stall_rg2, bubble_rg3, flush_rg1, flush_rg2,
           haz, mdu_last, stall_cycles
  );

  modport slave (
    input  opcode_rg2, opcode_rg3, mext_rg2, rs1_rg2, rs2_rg2, rd_rg3, br_taken_rg3,
    output stall_pc, stall_rg1, stall_rg2, bubble_rg3, flush_rg1, flush_rg2,
           haz, mdu_last, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_mdu_seq.sv
// Multi-cycle M-extension sequencer: IDLE/MDU_BUSY FSM plus down-counter.
// Only instantiated when MDU_STALL_EN is defined.
module mdu_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic br_taken,
  input  logic ld_use,
  input  logic mdu_op,
  output logic stall_c,
  output logic last_c
);

  localparam int unsigned CNT_BITS = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [0:0]  ST_IDLE  = 1'(HZ_IDLE);
  localparam logic [0:0]  ST_BUSY  = 1'(HZ_MDU_BUSY);

  logic [0:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall/last decode; a taken branch abandons any op in flight
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    last_c  = 1'b0;
    if (br_taken) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Load-use wins: the MDU op starts once the load result is forwardable
          if (ld_use) begin
            stall_c = 1'b1;
          end else if (mdu_op) begin
            stall_c = 1'b1;
            cnt_d   = CNT_BITS'(MDU_LAT - 2);
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - CNT_BITS'(1);
          end else begin
            last_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / MDU stall and branch flush controller feeding forwarding_unit.
// Optional feature macro: MDU_STALL_EN (multi-cycle M-extension sequencing).
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  logic     use_rs1;
  logic     use_rs2;
  logic     ld_use;
  logic     seq_stall;
  logic     seq_last;
  hz_ctrl_t ctrl;

  logic [CNT_W-1:0] stall_cnt_q;

  // Load-use detection against a load sitting in rg3
  always_comb begin
    use_rs1 = uses_rs1(bus.opcode_rg2);
    use_rs2 = uses_rs2(bus.opcode_rg2);
    ld_use  = (bus.opcode_rg3 == OPC_LOAD) && (bus.rd_rg3 != '0) &&
              ((use_rs1 && (bus.rs1_rg2 == bus.rd_rg3)) ||
               (use_rs2 && (bus.rs2_rg2 == bus.rd_rg3)));
  end

`ifdef MDU_STALL_EN
  logic mdu_op;
  assign mdu_op = (bus.opcode_rg2 == OPC_OP) && bus.mext_rg2;

  mdu_seq #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_taken (bus.br_taken_rg3),
    .ld_use   (ld_use),
    .mdu_op   (mdu_op),
    .stall_c  (seq_stall),
    .last_c   (seq_last)
  );
`else
  // Single-cycle MDU: only load-use can stall
  logic unused_cfg;
  assign unused_cfg = ^{bus.mext_rg2, 32'(MDU_LAT)};
  assign seq_stall  = ld_use;
  assign seq_last   = 1'b0;
`endif

  // Branch flush has top priority and suppresses any stall in the same cycle
  always_comb begin
    ctrl.flush    = bus.br_taken_rg3;
    ctrl.stall    = seq_stall && !bus.br_taken_rg3;
    ctrl.mdu_last = seq_last && !bus.br_taken_rg3;
  end

  assign bus.stall_pc   = ctrl.stall;
  assign bus.stall_rg1  = ctrl.stall;
  assign bus.stall_rg2  = ctrl.stall;
  assign bus.bubble_rg3 = ctrl.stall;
  assign bus.haz        = ctrl.stall;
  assign bus.flush_rg1  = ctrl.flush;
  assign bus.flush_rg2  = ctrl.flush;
  assign bus.mdu_last   = ctrl.mdu_last;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (ctrl.stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; expectations follow MDU_STALL_EN.
module tb_hazard_ctrl;
  import pipe_pkg::*;

`ifdef MDU_STALL_EN
  localparam logic M = 1'b1;
`else
  localparam logic M = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        flush;
    logic        last;
    logic [31:0] sc;
    string       tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl_if #(.CNT_W(2))  hif_sat ();

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif_sat)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_sc = '0;
  exp_t        sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [4:0] o2, input logic [4:0] o3, input logic mx,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic br);
    hif.opcode_rg2       = o2;  hif_sat.opcode_rg2   = o2;
    hif.opcode_rg3       = o3;  hif_sat.opcode_rg3   = o3;
    hif.mext_rg2         = mx;  hif_sat.mext_rg2     = mx;
    hif.rs1_rg2          = r1;  hif_sat.rs1_rg2      = r1;
    hif.rs2_rg2          = r2;  hif_sat.rs2_rg2      = r2;
    hif.rd_rg3           = rd;  hif_sat.rd_rg3       = rd;
    hif.br_taken_rg3     = br;  hif_sat.br_taken_rg3 = br;
  endtask

  task automatic push(input string tag, input logic es, input logic ef, input logic el);
    exp_t e;
    e.stall = es; e.flush = ef; e.last = el; e.sc = model_sc; e.tag = tag;
    sb.push_back(e);
    if (es) model_sc++;
  endtask

  task automatic compare();
    exp_t        e;
    logic [31:0] sat;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e   = sb.pop_front();
    sat = (e.sc > 32'd3) ? 32'd3 : e.sc;
    chk({e.tag, ".stall_pc"},     32'(hif.stall_pc),   32'(e.stall));
    chk({e.tag, ".stall_rg1"},    32'(hif.stall_rg1),  32'(e.stall));
    chk({e.tag, ".stall_rg2"},    32'(hif.stall_rg2),  32'(e.stall));
    chk({e.tag, ".bubble_rg3"},   32'(hif.bubble_rg3), 32'(e.stall));
    chk({e.tag, ".haz"},          32'(hif.haz),        32'(e.stall));
    chk({e.tag, ".flush_rg1"},    32'(hif.flush_rg1),  32'(e.flush));
    chk({e.tag, ".flush_rg2"},    32'(hif.flush_rg2),  32'(e.flush));
    chk({e.tag, ".mdu_last"},     32'(hif.mdu_last),   32'(e.last));
    chk({e.tag, ".stall_cycles"}, hif.stall_cycles,    e.sc);
    chk({e.tag, ".sat_cycles"},   32'(hif_sat.stall_cycles), sat);
  endtask

  // One pipeline cycle: drive after the edge, compare at the falling edge
  task automatic step(input string tag, input logic [4:0] o2, input logic [4:0] o3,
                      input logic mx, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic br,
                      input logic es, input logic ef, input logic el);
    drive(o2, o3, mx, r1, r2, rd, br);
    push(tag, es, ef, el);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, OPC_OP_IMM, OPC_OP_IMM, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // MUL x?,x1,x2 in rg2 for MDU_LAT cycles: three stalls then the last cycle
  task automatic mul_seq(input string tag);
    for (int k = 0; k < 3; k++)
      step($sformatf("%s_s%0d", tag, k), OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0,
           M, 1'b0, 1'b0);
    step({tag, "_last"}, OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, M);
  endtask

  initial begin
    drive(OPC_OP_IMM, OPC_OP_IMM, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    push("in_reset", 1'b0, 1'b0, 1'b0);
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle("idle0");
    step("lu_add",    OPC_OP,     OPC_LOAD,   1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    step("lu_bubble", OPC_OP,     OPC_OP_IMM, 1'b0, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld_x0",     OPC_OP,     OPC_LOAD,   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lui_x5",    OPC_LUI,    OPC_LOAD,   1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("store_rs2", OPC_STORE,  OPC_LOAD,   1'b0, 5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step("opimm_rs2", OPC_OP_IMM, OPC_LOAD,   1'b0, 5'd1, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_rs2",    OPC_BRANCH, OPC_LOAD,   1'b0, 5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step("jal_x3",    OPC_JAL,    OPC_LOAD,   1'b0, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_flush",  OPC_OP,     OPC_LOAD,   1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("idle1");

    mul_seq("mul_a");
    mul_seq("mul_b");

    step("ldmul_lu",  OPC_OP,     OPC_LOAD,   1'b1, 5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    mul_seq("ldmul");
    idle("idle2");

    step("fl_s0",  OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, M,    1'b0, 1'b0);
    step("fl_s1",  OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, M,    1'b0, 1'b0);
    step("fl_br",  OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    mul_seq("fl_new");
    idle("idle3");

    step("rs_s0",  OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, M,    1'b0, 1'b0);
    step("rs_s1",  OPC_OP, OPC_OP_IMM, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, M,    1'b0, 1'b0);
    drive(OPC_OP_IMM, OPC_OP_IMM, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_sc = '0;
    push("mid_reset", 1'b0, 1'b0, 1'b0);
    compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("post_reset");
    mul_seq("mul_c");

    for (int k = 0; k < 5; k++) begin
      step($sformatf("sat_lu%0d", k), OPC_OP, OPC_LOAD, 1'b0, 5'd4, 5'd1, 5'd4, 1'b0,
           1'b1, 1'b0, 1'b0);
      idle($sformatf("sat_gap%0d", k));
    end
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
